// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU arbiter: opcode and FSM state encodings plus
// the fixed result returned for a divide by zero.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'h0,
        ALU_SUB     = 4'h1,
        ALU_MUL     = 4'h2,
        ALU_DIV     = 4'h3,
        ALU_ACC_ADD = 4'h4,
        ALU_MAC     = 4'h5,
        ALU_ACC_SUB = 4'h6,
        ALU_AND     = 4'h7,
        ALU_OR      = 4'h8,
        ALU_XOR     = 4'h9,
        ALU_NOT     = 4'hA,
        ALU_SHL     = 4'hB,
        ALU_SHR     = 4'hC,
        ALU_EQ      = 4'hD,
        ALU_GT      = 4'hE,
        ALU_LT      = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of (req & mask) found
// scanning upward from ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic [NUM_REQ-1:0]         mask,
    output logic [NUM_REQ-1:0]         gnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] elig;
    logic               found;
    int                 pos;

    assign elig = req & mask;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!found && elig[IDX_W'(pos)]) begin
                gnt[IDX_W'(pos)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, one op in flight.
// Define ALU_ARB_LOCK_EN to honour req_lock (ALU ownership for accumulate chains).
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*4-1:0]         req_op,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    output logic [3:0]                   alu_sel,
    output logic                         alu_en,
    input  logic [DATA_W-1:0]            alu_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][3:0]        op_arr;
    logic [NUM_REQ-1:0][DATA_W-1:0] a_arr, b_arr;
    assign op_arr = req_op;
    assign a_arr  = req_a;
    assign b_arr  = req_b;

    arb_state_e          state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, arb_ptr, win_id;
    logic [NUM_REQ-1:0]  arb_mask, gnt;
    logic                accept, div0, rr_adv;
    logic [2:0]          cnt;

`ifdef ALU_ARB_LOCK_EN
    logic            lock_held, lock_rel;
    logic [ID_W-1:0] lock_owner;

    // Release is deferred to the response of the owner's unlocked op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_held  <= 1'b0;
            lock_rel   <= 1'b0;
            lock_owner <= '0;
        end else begin
            if (accept) begin
                if (req_lock[win_id]) begin
                    lock_held  <= 1'b1;
                    lock_owner <= win_id;
                    lock_rel   <= 1'b0;
                end else if (lock_held) begin
                    lock_rel <= 1'b1;
                end
            end
            if (state == ST_RESP && rsp_ready && lock_rel) begin
                lock_held <= 1'b0;
                lock_rel  <= 1'b0;
            end
        end
    end

    assign arb_ptr  = lock_held ? lock_owner : rr_ptr;
    assign arb_mask = lock_held ? (NUM_REQ'(1) << lock_owner) : '1;
    assign rr_adv   = !lock_held;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign arb_ptr     = rr_ptr;
    assign arb_mask    = '1;
    assign rr_adv      = 1'b1;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req  (req_valid),
        .ptr  (arb_ptr),
        .mask (arb_mask),
        .gnt  (gnt)
    );

    always_comb begin
        win_id = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (gnt[k]) win_id = ID_W'(k);
    end

    assign req_ready = (state == ST_IDLE) ? gnt : '0;
    assign accept    = |req_ready;
    assign div0      = (op_arr[win_id] == ALU_DIV) && (b_arr[win_id] == '0);
    assign alu_en    = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = div0 ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == 3'd1) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ALU operand registers only load for ops that will actually issue,
    // so they hold their last values across idle and divide-by-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (accept) begin
                    rsp_id <= win_id;
                    if (rr_adv)
                        rr_ptr <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
                    if (div0) begin
                        rsp_data <= DATA_W'(DIV0_RESULT);
                        rsp_err  <= 1'b1;
                    end else begin
                        alu_a   <= a_arr[win_id];
                        alu_b   <= b_arr[win_id];
                        alu_sel <= op_arr[win_id];
                        rsp_err <= 1'b0;
                    end
                end
                ST_ISSUE: cnt <= 3'(ALU_LAT);
                ST_WAIT: begin
                    if (cnt == 3'd1) rsp_data <= alu_result;
                    else             cnt      <= cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a registered ALU model (latency 1).
module tb_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ALU_LAT = 1;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_REQ-1:0]          req_valid, req_ready, req_lock;
    logic [NUM_REQ*4-1:0]        req_op;
    logic [NUM_REQ*DATA_W-1:0]   req_a, req_b;
    logic [DATA_W-1:0]           alu_a, alu_b, alu_result, rsp_data;
    logic [3:0]                  alu_sel;
    logic                        alu_en, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]                  rsp_id;

    int checks = 0, errors = 0, exp_en = 0, en_cnt = 0;

    typedef struct {
        int         id;
        logic [7:0] d;
        logic       e;
    } exp_t;
    exp_t sb_q[$];
    int   glog[$];
    logic [7:0] acc;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_lock(req_lock),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_en(alu_en),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    function automatic logic [7:0] alu_f(logic [3:0] s, logic [7:0] a, logic [7:0] b, logic [7:0] c);
        logic [7:0] r;
        case (s)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a * b;
            4'h3: r = (b != 0) ? a / b : 8'hFF;
            4'h4: r = c + a;
            4'h5: r = c + a * b;
            4'h6: r = c - a;
            4'h7: r = a & b;
            4'h8: r = a | b;
            4'h9: r = a ^ b;
            4'hA: r = ~a;
            4'hB: r = a << b[2:0];
            4'hC: r = a >> b[2:0];
            4'hD: r = {7'd0, a == b};
            4'hE: r = {7'd0, a > b};
            default: r = {7'd0, a < b};
        endcase
        return r;
    endfunction

    // ALU model: result register loads only on alu_en
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc <= 8'h00;
        else if (alu_en) acc <= alu_f(alu_sel, alu_a, alu_b, acc);
    end
    assign alu_result = acc;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) if (alu_en) en_cnt++;

    always @(negedge clk) begin
        if (rst_n && req_ready != 0)
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) glog.push_back(k);
    end

    // Monitor: pop and compare on every response handshake
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_err", rsp_err, e.e);
            end
        end
    end

    task automatic set_req(int i, logic [3:0] op, logic [7:0] a, logic [7:0] b, logic lk);
        req_op[4*i +: 4] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_lock[i]      = lk;
    endtask

    // Call at #1 after a rising edge; returns at #1 after the response handshake edge
    task automatic run_op(int i, logic [3:0] op, logic [7:0] a, logic [7:0] b, logic lk,
                          logic [7:0] exp_d, logic exp_e, int hold);
        bit   div0 = (op == 4'h3) && (b == 8'h00);
        bit   got  = 0;
        int   c    = 0;
        exp_t e;
        set_req(i, op, a, b, lk);
        req_valid[i] = 1'b1;
        if (hold > 0) rsp_ready = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        chk($sformatf("grant_req%0d", i), got, 1);
        if (!got) begin
            req_valid[i] = 1'b0;
            rsp_ready    = 1'b1;
            return;
        end
        chk("ready_onehot", req_ready, 32'(1) << i);
        e.id = i; e.d = exp_d; e.e = exp_e;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        @(negedge clk);
        if (div0) begin
            chk("div0_no_en", alu_en, 0);
            chk("div0_rsp_t1", rsp_valid, 1);
        end else begin
            exp_en++;
            chk("en_t1", alu_en, 1);
            chk("alu_a", alu_a, a);
            chk("alu_b", alu_b, b);
            chk("alu_sel", alu_sel, op);
            @(negedge clk);
            chk("en_t2", alu_en, 0);
            chk("rsp_early", rsp_valid, 0);
            @(negedge clk);
            chk("rsp_t3", rsp_valid, 1);
        end
        for (int h = 0; h < hold; h++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_id", rsp_id, i);
            chk("stall_data", rsp_data, exp_d);
            chk("stall_err", rsp_err, exp_e);
            chk("stall_ready", req_ready, 0);
            chk("stall_en", alu_en, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        while (!(rsp_valid && rsp_ready) && c < 64) begin
            @(negedge clk);
            c++;
        end
        chk("rsp_handshake", rsp_valid, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g, c;
        int exp_rr[5];
        rsp_ready = 1'b1;
        req_valid = '0; req_lock = '0; req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Round-robin: all four valid continuously, five accepts
        exp_rr = '{0, 1, 2, 3, 0};
        glog.delete();
        for (int k = 0; k < 4; k++) set_req(k, 4'h0, 8'(8'h10 * k + 1), 8'h02, 1'b0);
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            e.id = exp_rr[k]; e.d = 8'(8'h10 * exp_rr[k] + 3); e.e = 1'b0;
            sb_q.push_back(e);
        end
        req_valid = 4'hF;
        g = 0; c = 0;
        while (g < 5 && c < 200) begin
            @(negedge clk);
            c++;
            if (req_ready != 0) g++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        exp_en += 5;
        chk("rr_grants", g, 5);
        c = 0;
        while (sb_q.size() != 0 && c < 64) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk); #1;
        chk("rr_log_len", glog.size(), 5);
        for (int k = 0; k < 5 && k < glog.size(); k++)
            chk($sformatf("rr_gnt%0d", k), glog[k], exp_rr[k]);

        // Single ADD, timing and data
        run_op(0, 4'h0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 0);

        glog.delete();
`ifdef ALU_ARB_LOCK_EN
        set_req(0, 4'h0, 8'h01, 8'h01, 1'b0);
        req_valid[0] = 1'b1;
        run_op(1, 4'h0, 8'h02, 8'h03, 1'b1, 8'h05, 1'b0, 0);
        run_op(1, 4'h5, 8'h02, 8'h04, 1'b1, 8'h0D, 1'b0, 0);
        run_op(1, 4'h4, 8'h01, 8'h00, 1'b0, 8'h0E, 1'b0, 0);
        run_op(0, 4'h0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);
        chk("lock_log_len", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("lock_gnt0", glog[0], 1);
            chk("lock_gnt1", glog[1], 1);
            chk("lock_gnt2", glog[2], 1);
            chk("lock_gnt3", glog[3], 0);
        end
`else
        run_op(1, 4'h0, 8'h02, 8'h03, 1'b1, 8'h05, 1'b0, 0);
        set_req(1, 4'h5, 8'h02, 8'h04, 1'b1);
        req_valid[1] = 1'b1;
        run_op(0, 4'h0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);
        run_op(1, 4'h5, 8'h02, 8'h04, 1'b1, 8'h0A, 1'b0, 0);
        chk("nolock_log_len", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("nolock_gnt0", glog[0], 1);
            chk("nolock_gnt1", glog[1], 0);
            chk("nolock_gnt2", glog[2], 1);
        end
`endif

        // Normal divide, then divide by zero leaves the ALU inputs alone
        run_op(3, 4'h3, 8'h10, 8'h04, 1'b0, 8'h04, 1'b0, 0);
        run_op(2, 4'h3, 8'h10, 8'h00, 1'b0, 8'hFF, 1'b1, 0);
        chk("div0_hold_a", alu_a, 8'h10);
        chk("div0_hold_b", alu_b, 8'h04);
        chk("div0_hold_sel", alu_sel, 4'h3);
        chk("div0_en_total", en_cnt, exp_en);

        // Response stall with a competing request pending
        set_req(0, 4'h1, 8'h09, 8'h04, 1'b0);
        req_valid[0] = 1'b1;
        run_op(3, 4'h0, 8'h07, 8'h08, 1'b0, 8'h0F, 1'b0, 5);
        run_op(0, 4'h1, 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 0);

        // Reset during WAIT
        set_req(1, 4'h0, 8'h11, 8'h22, 1'b0);
        req_valid[1] = 1'b1;
        g = 0;
        for (int n = 0; n < 64 && g == 0; n++) begin
            @(negedge clk);
            if (req_ready[1]) g = 1;
        end
        chk("rstw_grant", g, 1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        exp_en++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_rsp_valid", rsp_valid, 0);
        chk("rstw_alu_en", alu_en, 0);
        chk("rstw_alu_a", alu_a, 0);
        chk("rstw_alu_b", alu_b, 0);
        chk("rstw_alu_sel", alu_sel, 0);
        chk("rstw_rsp_data", rsp_data, 0);
        chk("rstw_rsp_id", rsp_id, 0);
        chk("rstw_req_ready", req_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        glog.delete();
        set_req(3, 4'h0, 8'h01, 8'h01, 1'b0);
        req_valid[3] = 1'b1;
        run_op(1, 4'h0, 8'h20, 8'h01, 1'b0, 8'h21, 1'b0, 0);
        run_op(3, 4'h0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);
        chk("post_rst_log_len", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("post_rst_gnt0", glog[0], 1);
            chk("post_rst_gnt1", glog[1], 3);
        end

        repeat (3) @(negedge clk);
        chk("en_total", en_cnt, exp_en);
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
